// File: rtl/pll_reconf_seq.sv
// PLL retune sequencer: writes NTSC/PAL profile to the reconfig controller, holds core reset until relock (option PLL_RECONF_READBACK_EN).
// Latency: req to first mgmt_write 1 cycle; done follows relock plus SETTLE_CYC locked cycles.
// Backpressure: each mgmt transfer is held until mgmt_waitrequest=0; req is ignored while busy.
module pll_reconf_seq #(
  parameter logic [31:0] NTSC_K       = 32'd2537933971,
  parameter logic [31:0] PAL_K        = 32'd0,
  parameter logic [17:0] NTSC_M       = 18'h00404,
  parameter logic [17:0] PAL_M        = 18'h00404,
  parameter logic [17:0] NTSC_C0      = 18'h20302,
  parameter logic [17:0] PAL_C0       = 18'h20302,
  parameter logic [17:0] NTSC_C1      = 18'h00A0A,
  parameter logic [17:0] PAL_C1       = 18'h00A0A,
  parameter logic [23:0] LOCK_TIMEOUT = 24'd5_000_000,
  parameter logic [15:0] SETTLE_CYC   = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        sel_pal,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        core_reset_n
);

  typedef enum logic [3:0] {
    IDLE,
    WR_MODE,
    WR_M,
    WR_K,
    WR_C0,
    WR_C1,
    WR_START,
    WAIT_UNLOCK,
    WAIT_LOCK,
    SETTLE
`ifdef PLL_RECONF_READBACK_EN
    , RD_STAT
`endif
  } state_t;

  state_t      state_q, state_d, nxt;
  logic        wr_q, wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [23:0] tmr_q, tmr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        prof_q, prof_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        crst_q, crst_d;
  logic        fail;
  logic        locked_meta, locked_s;
  logic        unused_rd;
`ifdef PLL_RECONF_READBACK_EN
  logic        rd_q, rd_d;
`endif

  // {address, writedata} for each register write of the profile
  function automatic logic [37:0] wr_word(input state_t st, input logic pal);
    logic [37:0] w;
    w = '0;
    case (st)
      WR_MODE:  w = {6'd0, 32'd0};
      WR_M:     w = {6'd4, 14'd0, (pal ? PAL_M : NTSC_M)};
      WR_K:     w = {6'd7, (pal ? PAL_K : NTSC_K)};
      WR_C0:    w = {6'd5, 9'd0, 5'd0, (pal ? PAL_C0 : NTSC_C0)};
      WR_C1:    w = {6'd5, 9'd0, 5'd1, (pal ? PAL_C1 : NTSC_C1)};
      WR_START: w = {6'd2, 32'd1};
      default:  w = '0;
    endcase
    return w;
  endfunction

  function automatic state_t next_wr(input state_t st);
    state_t n;
    case (st)
      WR_MODE: n = WR_M;
      WR_M:    n = WR_K;
      WR_K:    n = WR_C0;
      WR_C0:   n = WR_C1;
      default: n = WR_START;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      prof_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      prof_q  <= prof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
    end
  end

`ifdef PLL_RECONF_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= 1'b0;
    else        rd_q <= rd_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    nxt     = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    prof_d  = prof_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    crst_d  = crst_q;
    fail    = 1'b0;
`ifdef PLL_RECONF_READBACK_EN
    rd_d    = rd_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WR_MODE;
          prof_d  = sel_pal;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          crst_d  = 1'b0;
          wr_d    = 1'b1;
          {addr_d, data_d} = wr_word(WR_MODE, sel_pal);
          tmr_d   = '0;
          cnt_d   = '0;
        end else if (err_q || !locked_s) begin
          // lock loss (or a failed retune) keeps the core in reset
          crst_d = 1'b0;
          cnt_d  = '0;
        end else if (!crst_q) begin
          if (cnt_q == SETTLE_CYC - 16'd1) begin
            crst_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      WR_MODE, WR_M, WR_K, WR_C0, WR_C1: begin
        if (wr_q) begin
          if (!mgmt_waitrequest) wr_d = 1'b0;
        end else begin
          nxt     = next_wr(state_q);
          state_d = nxt;
          wr_d    = 1'b1;
          {addr_d, data_d} = wr_word(nxt, prof_q);
        end
      end
      WR_START: begin
        if (wr_q) begin
          if (!mgmt_waitrequest) wr_d = 1'b0;
        end else begin
          tmr_d = '0;
`ifdef PLL_RECONF_READBACK_EN
          state_d = RD_STAT;
          rd_d    = 1'b1;
          addr_d  = 6'd1;
`else
          state_d = WAIT_UNLOCK;
`endif
        end
      end
`ifdef PLL_RECONF_READBACK_EN
      RD_STAT: begin
        // read stays asserted, so each waitrequest=0 cycle is one status poll
        if (!mgmt_waitrequest && mgmt_readdata[0]) begin
          rd_d    = 1'b0;
          state_d = WAIT_UNLOCK;
          tmr_d   = '0;
        end else if (tmr_q == LOCK_TIMEOUT - 24'd1) begin
          fail = 1'b1;
        end else begin
          tmr_d = tmr_q + 24'd1;
        end
      end
`endif
      WAIT_UNLOCK: begin
        // a fast relock can hide the unlock behind the synchroniser
        if (!locked_s || tmr_q == 24'd63) begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 24'd1;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = SETTLE;
          tmr_d   = '0;
          cnt_d   = '0;
        end else if (tmr_q == LOCK_TIMEOUT - 24'd1) begin
          fail = 1'b1;
        end else begin
          tmr_d = tmr_q + 24'd1;
        end
      end
      SETTLE: begin
        if (locked_s) begin
          if (cnt_q == SETTLE_CYC - 16'd1) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            crst_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = '0;
          if (tmr_q == LOCK_TIMEOUT - 24'd1) fail = 1'b1;
          else                                tmr_d = tmr_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d = IDLE;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      crst_d  = 1'b0;
      tmr_d   = '0;
      cnt_d   = '0;
`ifdef PLL_RECONF_READBACK_EN
      rd_d    = 1'b0;
`endif
    end
  end

  assign unused_rd      = ^mgmt_readdata;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mgmt_address   = addr_q;
  assign mgmt_write     = wr_q;
  assign mgmt_writedata = data_q;
  assign core_reset_n   = crst_q;
`ifdef PLL_RECONF_READBACK_EN
  assign mgmt_read      = rd_q;
`else
  assign mgmt_read      = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Directed bench for pll_reconf_seq: profile write vectors plus reset, stall, timeout and lock-tracking sequences.
module tb_pll_reconf_seq;
  localparam logic [23:0] LT   = 24'd200;
  localparam logic [15:0] SC   = 16'd8;
  localparam logic [31:0] P_K  = 32'hCAFE_0001;
  localparam logic [17:0] P_M  = 18'h00505;
  localparam logic [17:0] P_C0 = 18'h10101;
  localparam logic [17:0] P_C1 = 18'h00303;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        sel_pal = 1'b0;
  logic        waitrequest = 1'b0;
  logic        pll_locked = 1'b1;
  logic [31:0] readdata = 32'h1;
  logic        busy, done, err, mgmt_write, mgmt_read, core_reset_n;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;

  always #5 clk = ~clk;

  pll_reconf_seq #(
    .PAL_K(P_K), .PAL_M(P_M), .PAL_C0(P_C0), .PAL_C1(P_C1),
    .LOCK_TIMEOUT(LT), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel_pal(sel_pal),
    .busy(busy), .done(done), .err(err),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(readdata),
    .mgmt_waitrequest(waitrequest), .pll_locked(pll_locked),
    .core_reset_n(core_reset_n)
  );

  int n_cmp = 0;
  int n_err = 0;

  // accepted-write log
  int          wr_cnt = 0;
  logic [5:0]  log_a [64];
  logic [31:0] log_d [64];
  always @(posedge clk) begin
    if (rst_n && mgmt_write && !waitrequest) begin
      log_a[wr_cnt % 64] <= mgmt_address;
      log_d[wr_cnt % 64] <= mgmt_writedata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // waitrequest driver: stalls the first write to stall_addr for stall_len cycles
  int          stall_id = 0;
  int          served_id = 0;
  int          stall_len = 0;
  int          stall_stable = 0;
  logic [5:0]  stall_addr = 6'd0;
  logic [31:0] stall_dat;
  always begin
    @(posedge clk);
    #1;
    if (served_id != stall_id && rst_n && mgmt_write && mgmt_address == stall_addr) begin
      served_id    = stall_id;
      stall_dat    = mgmt_writedata;
      waitrequest  = 1'b1;
      stall_stable = 1;
      for (int i = 0; i < stall_len; i++) begin
        @(posedge clk);
        #1;
        if (!rst_n) break;
        if (mgmt_write && mgmt_address == stall_addr && mgmt_writedata == stall_dat)
          stall_stable++;
      end
      waitrequest = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic            sel;
    logic            stall;
    logic            midreq;
    logic [5:0][31:0] dat;
  } vec_t;

  vec_t             vt [4];
  logic [5:0][5:0]  exp_a;
  logic [5:0][31:0] ntsc_w, pal_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic wait_writes(input int base, input string name);
    int n;
    n = 0;
    while (wr_cnt < base + 6 && n < 300) begin
      tick();
      n++;
    end
    chk(name, 32'(wr_cnt - base), 32'd6);
  endtask

  task automatic bounce_and_done(input string name);
    int n;
    pll_locked = 1'b0;
    repeat (6) tick();
    pll_locked = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_crst"}, 32'(core_reset_n), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    tick();
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int base;
    base = wr_cnt;
    if (v.stall) begin
      stall_addr = 6'd7;
      stall_len  = 10;
      stall_id++;
    end
    req = 1'b1;
    sel_pal = v.sel;
    tick();
    req = 1'b0;
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d_first_wr", idx), 32'(mgmt_write), 32'd1);
    chk($sformatf("v%0d_first_addr", idx), 32'(mgmt_address), 32'd0);
    chk($sformatf("v%0d_crst_low", idx), 32'(core_reset_n), 32'd0);
    if (v.midreq) begin
      tick();
      req = 1'b1;
      sel_pal = ~v.sel;
      tick();
      req = 1'b0;
    end
    wait_writes(base, $sformatf("v%0d_wr_count", idx));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("v%0d_addr%0d", idx, i), 32'(log_a[(base + i) % 64]), 32'(exp_a[i]));
      chk($sformatf("v%0d_data%0d", idx, i), log_d[(base + i) % 64], v.dat[i]);
    end
    if (v.stall) chk($sformatf("v%0d_k_stable", idx), 32'(stall_stable), 32'd11);
    bounce_and_done($sformatf("v%0d", idx));
    chk($sformatf("v%0d_err", idx), 32'(err), 32'd0);
    chk($sformatf("v%0d_wr_total", idx), 32'(wr_cnt - base), 32'd6);
  endtask

  initial begin
    int n;
    int base;
    logic found;

    exp_a  = {6'd2, 6'd5, 6'd5, 6'd7, 6'd4, 6'd0};
    ntsc_w = {32'd1, 32'h0004_0A0A, 32'h0002_0302, 32'd2537933971, 32'h0000_0404, 32'd0};
    pal_w  = {32'd1, 32'h0004_0303, 32'h0001_0101, 32'hCAFE_0001, 32'h0000_0505, 32'd0};
    vt[0] = '{sel: 1'b0, stall: 1'b0, midreq: 1'b0, dat: ntsc_w};
    vt[1] = '{sel: 1'b1, stall: 1'b0, midreq: 1'b1, dat: pal_w};
    vt[2] = '{sel: 1'b0, stall: 1'b1, midreq: 1'b0, dat: ntsc_w};
    vt[3] = '{sel: 1'b1, stall: 1'b1, midreq: 1'b1, dat: pal_w};

    // reset state
    repeat (3) tick();
    chk("rst_write", 32'(mgmt_write), 32'd0);
    chk("rst_read", 32'(mgmt_read), 32'd0);
    chk("rst_addr", 32'(mgmt_address), 32'd0);
    chk("rst_data", mgmt_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_crst", 32'(core_reset_n), 32'd0);

    // power-up: lock already present, core released after sync + settle
    rst_n = 1'b1;
    n = 0;
    while (!core_reset_n && n < 100) begin
      tick();
      n++;
    end
    chk("powerup_cycles", 32'(n), 32'(SC) + 32'd2);
    chk("powerup_busy", 32'(busy), 32'd0);
    chk("powerup_writes", 32'(wr_cnt), 32'd0);

    for (int i = 0; i < 4; i++) begin
      repeat (3) tick();
      run_vec(vt[i], i);
    end

    // lock loss while idle forces core reset; relock releases after settle
    pll_locked = 1'b0;
    repeat (4) tick();
    chk("idle_lock_loss", 32'(core_reset_n), 32'd0);
    pll_locked = 1'b1;
    n = 0;
    while (!core_reset_n && n < 100) begin
      tick();
      n++;
    end
    chk("idle_relock_cycles", 32'(n), 32'(SC) + 32'd2);

    // lock never returns
    base = wr_cnt;
    req = 1'b1;
    sel_pal = 1'b0;
    tick();
    req = 1'b0;
    wait_writes(base, "to_wr_count");
    pll_locked = 1'b0;
    n = 0;
    while (!err && n < 1000) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'(LT) + 32'd3);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_crst", 32'(core_reset_n), 32'd0);
    pll_locked = 1'b1;
    repeat (30) tick();
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_crst_held", 32'(core_reset_n), 32'd0);
    base = wr_cnt;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("to_err_clear", 32'(err), 32'd0);
    chk("to_req_busy", 32'(busy), 32'd1);
    wait_writes(base, "to_retry_wr_count");
    bounce_and_done("to_retry");

    // reset asserted mid-transfer on a stalled C0 write
    stall_addr = 6'd5;
    stall_len  = 1000;
    stall_id++;
    req = 1'b1;
    sel_pal = 1'b0;
    tick();
    req = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      tick();
      n++;
      found = mgmt_write && mgmt_address == 6'd5 && waitrequest;
    end
    chk("rstmid_found_c0", 32'(found), 32'd1);
    repeat (2) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_write", 32'(mgmt_write), 32'd0);
    chk("rstmid_addr", 32'(mgmt_address), 32'd0);
    chk("rstmid_data", mgmt_writedata, 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_crst", 32'(core_reset_n), 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    base = wr_cnt;
    repeat (20) tick();
    chk("rstmid_idle_writes", 32'(wr_cnt - base), 32'd0);
    chk("rstmid_idle_busy", 32'(busy), 32'd0);
    chk("rstmid_relock_crst", 32'(core_reset_n), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
